// File: rtl/keycode_voice_alloc_pkg.sv
// Shared types and the HID-to-semitone key map for the keycode voice allocator.
package keycode_voice_alloc_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      RELEASE = 2'd1,
      ASSIGN  = 2'd2
   } alloc_state_t;

   localparam int MAX_NOTE = 127;

   typedef struct packed {
      logic       valid;
      logic [3:0] semi;
   } semi_t;

   // One octave plus the upper C on a QWERTY row; everything else is unmapped.
   function automatic semi_t key_to_semi(input logic [7:0] keycode);
      semi_t r;
      r.valid = 1'b1;
      r.semi  = 4'd0;
      case (keycode)
         8'h04: r.semi = 4'd0;
         8'h1A: r.semi = 4'd1;
         8'h16: r.semi = 4'd2;
         8'h08: r.semi = 4'd3;
         8'h07: r.semi = 4'd4;
         8'h09: r.semi = 4'd5;
         8'h17: r.semi = 4'd6;
         8'h0A: r.semi = 4'd7;
         8'h1C: r.semi = 4'd8;
         8'h0B: r.semi = 4'd9;
         8'h18: r.semi = 4'd10;
         8'h0D: r.semi = 4'd11;
         8'h0E: r.semi = 4'd12;
         default: r.valid = 1'b0;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/keycode_voice_alloc_if.sv
// Report-in / voice-out bundle between the USB keycode source and the voice allocator.
interface keycode_voice_alloc_if
   import keycode_voice_alloc_pkg::*;
#(
   parameter int NUM_KEYS   = 4,
   parameter int NUM_VOICES = 4,
   parameter int KEY_W      = 8,
   parameter int OCT_W      = 3,
   parameter int NOTE_W     = 7
) ();
   // scan_strobe_i is a one-cycle valid with no ready: a report is accepted only while busy_o is
   // low; a strobe seen while busy_o is high is dropped and answered with a one-cycle overrun_o.
   logic [NUM_KEYS*KEY_W-1:0]    keycode_i;
   logic [OCT_W-1:0]             octave_i;
   logic                         scan_strobe_i;
   logic [NUM_VOICES*NOTE_W-1:0] voice_note_o;
   logic [NUM_VOICES-1:0]        voice_gate_o;
   logic [NUM_VOICES-1:0]        voice_trig_o;
   logic                         busy_o;
   logic                         steal_o;
   logic                         overrun_o;
   alloc_state_t                 fsm_state;

   modport master (
      output keycode_i, octave_i, scan_strobe_i,
      input  voice_note_o, voice_gate_o, voice_trig_o, busy_o, steal_o, overrun_o, fsm_state
   );

   modport slave (
      input  keycode_i, octave_i, scan_strobe_i,
      output voice_note_o, voice_gate_o, voice_trig_o, busy_o, steal_o, overrun_o, fsm_state
   );
endinterface

// File: rtl/keycode_voice_alloc_voice_pick.sv
// Chooses the voice for a new note: lowest free voice, otherwise the oldest gated one (a steal).
module keycode_voice_alloc_voice_pick #(
   parameter int NUM_VOICES = 4,
   parameter int AGE_W      = 4,
   parameter int IDX_W      = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1
) (
   input  logic [NUM_VOICES-1:0]       gate,
   input  logic [NUM_VOICES*AGE_W-1:0] age,
   output logic [IDX_W-1:0]            target,
   output logic                        steal
);

   logic [AGE_W-1:0] best_age;

   always_comb begin
      target   = '0;
      steal    = 1'b1;
      best_age = age[AGE_W-1:0];
      // Descending scan so the lowest free index wins.
      for (int v = NUM_VOICES - 1; v >= 0; v--) begin
         if (!gate[v]) begin
            target = IDX_W'(v);
            steal  = 1'b0;
         end
      end
      // Strict compare keeps the lowest index on equal ages.
      if (steal) begin
         for (int v = 1; v < NUM_VOICES; v++) begin
            if (age[v*AGE_W +: AGE_W] > best_age) begin
               best_age = age[v*AGE_W +: AGE_W];
               target   = IDX_W'(v);
            end
         end
      end
   end

endmodule

// File: rtl/keycode_voice_alloc.sv
// Polyphonic voice allocator: diffs each HID report against held voices, releases, then assigns.
module keycode_voice_alloc
   import keycode_voice_alloc_pkg::*;
#(
   parameter int NUM_KEYS   = 4,
   parameter int NUM_VOICES = 4,
   parameter int KEY_W      = 8,
   parameter int OCT_W      = 3,
   parameter int NOTE_W     = 7,
   parameter int BASE_NOTE  = 24,
   parameter int AGE_W      = 4
) (
   input logic                 clk_clk,
   input logic                 reset_reset,
   keycode_voice_alloc_if.slave bus
);

   localparam logic [1:0] S_IDLE    = 2'(IDLE);
   localparam logic [1:0] S_RELEASE = 2'(RELEASE);
   localparam logic [1:0] S_ASSIGN  = 2'(ASSIGN);
   localparam int IDX_W = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
   localparam int CNT_W = $clog2(((NUM_KEYS > NUM_VOICES) ? NUM_KEYS : NUM_VOICES) + 1);
   localparam int SUM_W = NOTE_W + 2;
   localparam logic [SUM_W-1:0] NOTE_MAX = SUM_W'((1 << NOTE_W) - 1);

   logic [1:0]                  state_q;
   logic [CNT_W-1:0]            idx_q;
   logic [NUM_KEYS*KEY_W-1:0]   snap_q;
   logic [OCT_W-1:0]            oct_q;
   logic [KEY_W-1:0]            key_q  [NUM_VOICES];
   logic [NOTE_W-1:0]           note_q [NUM_VOICES];
   logic [NUM_VOICES-1:0]       gate_q;
   logic [NUM_VOICES-1:0]       trig_q;
   logic [NUM_VOICES*AGE_W-1:0] age_q;
   logic                        steal_q;
   logic                        overrun_q;

   logic [KEY_W-1:0]  cur_key;
   logic              cur_gate;
   logic              in_snap;
   logic [KEY_W-1:0]  cur_code;
   logic              slot_valid;
   logic              held;
   semi_t             semi;
   logic [SUM_W-1:0]  note_sum;
   logic [NOTE_W-1:0] new_note;
   logic              release_now;
   logic              do_assign;
   logic [IDX_W-1:0]  pick_idx;
   logic              pick_steal;

   always_comb begin
      cur_key    = '0;
      cur_gate   = 1'b0;
      in_snap    = 1'b0;
      cur_code   = '0;
      slot_valid = 1'b0;
      held       = 1'b0;
      for (int v = 0; v < NUM_VOICES; v++) begin
         if (idx_q == CNT_W'(v)) begin
            cur_key  = key_q[v];
            cur_gate = gate_q[v];
         end
      end
      for (int k = 0; k < NUM_KEYS; k++) begin
         if (snap_q[k*KEY_W +: KEY_W] == cur_key) in_snap = 1'b1;
         if (idx_q == CNT_W'(k)) begin
            cur_code   = snap_q[k*KEY_W +: KEY_W];
            slot_valid = 1'b1;
         end
      end
      // A key already sounding is not reallocated; this also collapses duplicates in one report.
      for (int v = 0; v < NUM_VOICES; v++) begin
         if (gate_q[v] && key_q[v] == cur_code) held = 1'b1;
      end
   end

   always_comb begin
      semi     = key_to_semi(8'(cur_code));
      note_sum = SUM_W'(BASE_NOTE) + SUM_W'(12) * SUM_W'(oct_q) + SUM_W'(semi.semi);
      new_note = (note_sum > NOTE_MAX) ? NOTE_MAX[NOTE_W-1:0] : note_sum[NOTE_W-1:0];
   end

   assign release_now = (state_q == S_RELEASE) && cur_gate && !in_snap;
   assign do_assign   = (state_q == S_ASSIGN) && slot_valid && (cur_code != '0) &&
                        semi.valid && !held;

   keycode_voice_alloc_voice_pick #(
      .NUM_VOICES (NUM_VOICES),
      .AGE_W      (AGE_W),
      .IDX_W      (IDX_W)
   ) u_pick (
      .gate   (gate_q),
      .age    (age_q),
      .target (pick_idx),
      .steal  (pick_steal)
   );

   always_ff @(posedge clk_clk or posedge reset_reset) begin
      if (reset_reset) begin
         state_q   <= S_IDLE;
         idx_q     <= '0;
         snap_q    <= '0;
         oct_q     <= '0;
         gate_q    <= '0;
         trig_q    <= '0;
         age_q     <= '0;
         steal_q   <= 1'b0;
         overrun_q <= 1'b0;
         for (int v = 0; v < NUM_VOICES; v++) begin
            key_q[v]  <= '0;
            note_q[v] <= '0;
         end
      end else begin
         trig_q    <= '0;
         steal_q   <= 1'b0;
         overrun_q <= (state_q != S_IDLE) && bus.scan_strobe_i;
         case (state_q)
            S_IDLE: begin
               if (bus.scan_strobe_i) begin
                  snap_q  <= bus.keycode_i;
                  oct_q   <= bus.octave_i;
                  idx_q   <= '0;
                  state_q <= S_RELEASE;
               end
            end
            S_RELEASE: begin
               for (int v = 0; v < NUM_VOICES; v++) begin
                  if (release_now && idx_q == CNT_W'(v)) gate_q[v] <= 1'b0;
               end
               if (idx_q == CNT_W'(NUM_VOICES - 1)) begin
                  idx_q   <= '0;
                  state_q <= S_ASSIGN;
               end else begin
                  idx_q <= idx_q + 1'b1;
               end
            end
            S_ASSIGN: begin
               if (do_assign) begin
                  key_q[pick_idx]  <= cur_code;
                  note_q[pick_idx] <= new_note;
                  gate_q[pick_idx] <= 1'b1;
                  trig_q[pick_idx] <= 1'b1;
                  steal_q          <= pick_steal;
                  for (int v = 0; v < NUM_VOICES; v++) begin
                     if (IDX_W'(v) == pick_idx)
                        age_q[v*AGE_W +: AGE_W] <= '0;
                     else if (gate_q[v] && age_q[v*AGE_W +: AGE_W] != '1)
                        age_q[v*AGE_W +: AGE_W] <= age_q[v*AGE_W +: AGE_W] + 1'b1;
                  end
               end
               // idx == NUM_KEYS is a tail cycle so the last slot's trig/steal pulse lands while busy.
               if (idx_q == CNT_W'(NUM_KEYS)) begin
                  idx_q   <= '0;
                  state_q <= S_IDLE;
               end else begin
                  idx_q <= idx_q + 1'b1;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   always_comb begin
      bus.voice_note_o = '0;
      for (int v = 0; v < NUM_VOICES; v++) bus.voice_note_o[v*NOTE_W +: NOTE_W] = note_q[v];
   end

   assign bus.voice_gate_o = gate_q;
   assign bus.voice_trig_o = trig_q;
   assign bus.busy_o       = (state_q != S_IDLE);
   assign bus.steal_o      = steal_q;
   assign bus.overrun_o    = overrun_q;
   assign bus.fsm_state    = alloc_state_t'(state_q);

endmodule

// File: tb/tb_keycode_voice_alloc.sv
// Bench for keycode_voice_alloc: three parameterisations checked against a report-level model.
module tb_keycode_voice_alloc;
   import keycode_voice_alloc_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   int   n_checks = 0;
   int   n_errors = 0;
   int   sel = 0;
   logic strobe = 1'b0;
   logic [2:0]  octave = '0;
   logic [47:0] rep_bits = '0;
   int   rep[6];
   int   last_steal;
   int   last_trig[4];

   keycode_voice_alloc_if if_a ();
   keycode_voice_alloc_if #(.NUM_KEYS(6)) if_k6 ();
   keycode_voice_alloc_if if_b ();

   keycode_voice_alloc u_a (.clk_clk(clk), .reset_reset(rst), .bus(if_a.slave));
   keycode_voice_alloc #(.NUM_KEYS(6)) u_k6 (.clk_clk(clk), .reset_reset(rst), .bus(if_k6.slave));
   keycode_voice_alloc #(.BASE_NOTE(100)) u_b (.clk_clk(clk), .reset_reset(rst), .bus(if_b.slave));

   assign if_a.keycode_i      = rep_bits[31:0];
   assign if_k6.keycode_i     = rep_bits;
   assign if_b.keycode_i      = rep_bits[31:0];
   assign if_a.octave_i       = octave;
   assign if_k6.octave_i      = octave;
   assign if_b.octave_i       = octave;
   assign if_a.scan_strobe_i  = strobe && (sel == 0);
   assign if_k6.scan_strobe_i = strobe && (sel == 1);
   assign if_b.scan_strobe_i  = strobe && (sel == 2);

   logic [27:0]  mon_note;
   logic [3:0]   mon_gate, mon_trig;
   logic         mon_busy, mon_steal, mon_ovr;
   alloc_state_t mon_state;

   always_comb begin
      case (sel)
         1: begin
            mon_note = if_k6.voice_note_o; mon_gate = if_k6.voice_gate_o; mon_trig = if_k6.voice_trig_o;
            mon_busy = if_k6.busy_o; mon_steal = if_k6.steal_o; mon_ovr = if_k6.overrun_o;
            mon_state = if_k6.fsm_state;
         end
         2: begin
            mon_note = if_b.voice_note_o; mon_gate = if_b.voice_gate_o; mon_trig = if_b.voice_trig_o;
            mon_busy = if_b.busy_o; mon_steal = if_b.steal_o; mon_ovr = if_b.overrun_o;
            mon_state = if_b.fsm_state;
         end
         default: begin
            mon_note = if_a.voice_note_o; mon_gate = if_a.voice_gate_o; mon_trig = if_a.voice_trig_o;
            mon_busy = if_a.busy_o; mon_steal = if_a.steal_o; mon_ovr = if_a.overrun_o;
            mon_state = if_a.fsm_state;
         end
      endcase
   end

   // ---------------- reference model (whole-report granularity) ----------------
   int m_key[4], m_note[4], m_age[4], m_trig[4], m_steal;
   bit m_gate[4];
   byte unsigned semi_codes[13] = '{8'h04, 8'h1A, 8'h16, 8'h08, 8'h07, 8'h09, 8'h17,
                                    8'h0A, 8'h1C, 8'h0B, 8'h18, 8'h0D, 8'h0E};

   function automatic int semi_of(input int code);
      for (int i = 0; i < 13; i++) if (code != 0 && int'(semi_codes[i]) == code) return i;
      return -1;
   endfunction

   task automatic model_reset();
      for (int v = 0; v < 4; v++) begin
         m_key[v] = 0; m_note[v] = 0; m_age[v] = 0; m_trig[v] = 0; m_gate[v] = 0;
      end
      m_steal = 0;
   endtask

   task automatic model_scan(input int nk, input int oct, input int base);
      int t, s, c;
      bit found;
      m_steal = 0;
      for (int v = 0; v < 4; v++) m_trig[v] = 0;
      for (int v = 0; v < 4; v++) begin
         found = 0;
         for (int k = 0; k < nk; k++) if (rep[k] == m_key[v]) found = 1;
         if (m_gate[v] && !found) m_gate[v] = 0;
      end
      for (int k = 0; k < nk; k++) begin
         c = rep[k];
         s = semi_of(c);
         found = 0;
         for (int v = 0; v < 4; v++) if (m_gate[v] && m_key[v] == c) found = 1;
         if (s < 0 || found) continue;
         t = -1;
         for (int v = 0; v < 4; v++) if (!m_gate[v] && t < 0) t = v;
         if (t < 0) begin
            t = 0;
            for (int v = 1; v < 4; v++) if (m_age[v] > m_age[t]) t = v;
            m_steal++;
         end
         for (int v = 0; v < 4; v++) if (v != t && m_gate[v]) m_age[v] = (m_age[v] < 15) ? m_age[v] + 1 : 15;
         m_age[t]  = 0;
         m_key[t]  = c;
         m_note[t] = (base + 12 * oct + s > 127) ? 127 : base + 12 * oct + s;
         m_gate[t] = 1;
         m_trig[t]++;
      end
   endtask

   // ---------------- drivers ----------------
   task automatic apply_reset();
      @(negedge clk);
      rst = 1'b1; strobe = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      model_reset();
   endtask

   task automatic set_rep(input int r0, input int r1, input int r2, input int r3,
                          input int r4, input int r5);
      rep[0] = r0; rep[1] = r1; rep[2] = r2; rep[3] = r3; rep[4] = r4; rep[5] = r5;
   endtask

   // Drives one report to the selected instance, watches the whole scan, compares with the model.
   task automatic run_scan(input string tag, input int oct, input bit inject);
      int nk, base, cyc, busy_n, steal_n, ovr_n;
      int trig_n[4];
      nk   = (sel == 1) ? 6 : 4;
      base = (sel == 2) ? 100 : 24;
      for (int k = 0; k < 6; k++) begin
         if (k >= nk) rep[k] = 0;
         rep_bits[k*8 +: 8] = 8'(rep[k]);
      end
      @(negedge clk);
      octave = 3'(oct);
      strobe = 1'b1;
      @(negedge clk);
      strobe = 1'b0;
      busy_n = 0; steal_n = 0; ovr_n = 0; cyc = 0;
      for (int v = 0; v < 4; v++) trig_n[v] = 0;
      while (mon_busy && cyc < 40) begin
         busy_n++;
         for (int v = 0; v < 4; v++) if (mon_trig[v]) trig_n[v]++;
         if (mon_steal) steal_n++;
         if (mon_ovr) ovr_n++;
         cyc++;
         if (inject && cyc == 2) begin
            rep_bits = 48'h0E0E_0E0E_0E0E;
            octave   = 3'd6;
            strobe   = 1'b1;
         end else begin
            strobe = 1'b0;
         end
         @(negedge clk);
      end
      strobe = 1'b0;
      model_scan(nk, oct, base);
      last_steal = steal_n;
      for (int v = 0; v < 4; v++) last_trig[v] = trig_n[v];

      n_checks++;
      if (busy_n !== 1 + 4 + nk) begin
         n_errors++; $display("FAIL %s busy_cycles: got %0d expected %0d", tag, busy_n, 1 + 4 + nk);
      end
      n_checks++;
      if (steal_n !== m_steal) begin
         n_errors++; $display("FAIL %s steal_pulses: got %0d expected %0d", tag, steal_n, m_steal);
      end
      n_checks++;
      if (ovr_n !== (inject ? 1 : 0)) begin
         n_errors++; $display("FAIL %s overrun_pulses: got %0d expected %0d", tag, ovr_n, inject ? 1 : 0);
      end
      for (int v = 0; v < 4; v++) begin
         n_checks++;
         if (mon_gate[v] !== m_gate[v]) begin
            n_errors++; $display("FAIL %s gate%0d: got %0b expected %0b", tag, v, mon_gate[v], m_gate[v]);
         end
         n_checks++;
         if (int'(mon_note[v*7 +: 7]) !== m_note[v]) begin
            n_errors++; $display("FAIL %s note%0d: got %0d expected %0d", tag, v, mon_note[v*7 +: 7], m_note[v]);
         end
         n_checks++;
         if (trig_n[v] !== m_trig[v]) begin
            n_errors++; $display("FAIL %s trig%0d_pulses: got %0d expected %0d", tag, v, trig_n[v], m_trig[v]);
         end
      end
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      for (int s = 0; s < 3; s++) begin
         sel = s;
         #1;
         n_checks++;
         if (mon_gate !== 4'h0 || mon_trig !== 4'h0 || mon_note !== 28'h0) begin
            n_errors++; $display("FAIL reset_voices inst%0d: gate=%h trig=%h note=%h expected all 0", s, mon_gate, mon_trig, mon_note);
         end
         n_checks++;
         if (mon_busy !== 1'b0 || mon_steal !== 1'b0 || mon_ovr !== 1'b0 || mon_state !== IDLE) begin
            n_errors++; $display("FAIL reset_status inst%0d: busy=%b steal=%b ovr=%b state=%0d expected 0,0,0,IDLE", s, mon_busy, mon_steal, mon_ovr, mon_state);
         end
      end
      sel = 0;
   endtask

   task automatic test_single_press();
      set_rep(8'h04, 0, 0, 0, 0, 0);
      run_scan("single_press", 3, 1'b0);
      n_checks++;
      if (mon_note[6:0] !== 7'd60 || last_trig[0] !== 1) begin
         n_errors++; $display("FAIL single_press_c4: note0=%0d trig0=%0d expected 60 and 1", mon_note[6:0], last_trig[0]);
      end
   endtask

   task automatic test_release();
      set_rep(0, 0, 0, 0, 0, 0);
      run_scan("release", 5, 1'b0);
      n_checks++;
      if (mon_gate[0] !== 1'b0 || mon_note[6:0] !== 7'd60) begin
         n_errors++; $display("FAIL release_hold_note: gate0=%b note0=%0d expected 0 and 60", mon_gate[0], mon_note[6:0]);
      end
   endtask

   task automatic test_replace();
      set_rep(8'h04, 8'h16, 8'h07, 8'h09, 0, 0);
      run_scan("replace_fill", 3, 1'b0);
      set_rep(8'h04, 8'h16, 8'h07, 8'h0A, 0, 0);
      run_scan("replace_swap", 3, 1'b0);
      n_checks++;
      if (mon_gate !== 4'hF || mon_note[21 +: 7] !== 7'd67 || last_steal !== 0 || last_trig[3] !== 1) begin
         n_errors++; $display("FAIL replace_voice3: gate=%h note3=%0d steal=%0d trig3=%0d expected F,67,0,1", mon_gate, mon_note[21 +: 7], last_steal, last_trig[3]);
      end
   endtask

   task automatic test_steal_six();
      apply_reset();
      sel = 1;
      set_rep(8'h04, 8'h1A, 8'h16, 8'h08, 8'h07, 8'h09);
      run_scan("steal_six", 4, 1'b0);
      n_checks++;
      if (last_steal !== 2 || last_trig[0] !== 2 || last_trig[1] !== 2 || mon_gate !== 4'hF) begin
         n_errors++; $display("FAIL steal_oldest: steal=%0d trig0=%0d trig1=%0d gate=%h expected 2,2,2,F", last_steal, last_trig[0], last_trig[1], mon_gate);
      end
   endtask

   task automatic test_dup_unmapped();
      apply_reset();
      sel = 0;
      set_rep(0, 8'h33, 8'h04, 8'h04, 0, 0);
      run_scan("dup_unmapped", 3, 1'b0);
      n_checks++;
      if (mon_gate !== 4'b0001) begin
         n_errors++; $display("FAIL dup_single_voice: gate=%b expected 0001", mon_gate);
      end
      set_rep(8'h0E, 0, 0, 0, 0, 0);
      run_scan("top_octave", 7, 1'b0);
      n_checks++;
      if (mon_note[6:0] !== 7'd120) begin
         n_errors++; $display("FAIL top_octave_note: got %0d expected 120", mon_note[6:0]);
      end
      apply_reset();
      sel = 2;
      set_rep(8'h0E, 0, 0, 0, 0, 0);
      run_scan("saturate", 7, 1'b0);
      n_checks++;
      if (mon_note[6:0] !== 7'd127) begin
         n_errors++; $display("FAIL saturate_note: got %0d expected 127", mon_note[6:0]);
      end
   endtask

   task automatic test_overrun();
      apply_reset();
      sel = 0;
      set_rep(8'h04, 8'h16, 0, 0, 0, 0);
      run_scan("overrun", 2, 1'b1);
   endtask

   task automatic test_reset_mid_scan();
      int cyc;
      set_rep(8'h07, 8'h08, 8'h09, 8'h0A, 0, 0);
      for (int k = 0; k < 6; k++) rep_bits[k*8 +: 8] = 8'(rep[k]);
      @(negedge clk);
      octave = 3'd1;
      strobe = 1'b1;
      @(negedge clk);
      strobe = 1'b0;
      cyc = 0;
      while (mon_state !== ASSIGN && cyc < 20) begin
         cyc++;
         @(negedge clk);
      end
      n_checks++;
      if (cyc >= 20) begin
         n_errors++; $display("FAIL reach_assign: state=%0d expected ASSIGN within 20 cycles", mon_state);
      end
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      #1;
      n_checks++;
      if (mon_gate !== 4'h0 || mon_trig !== 4'h0 || mon_state !== IDLE || mon_busy !== 1'b0) begin
         n_errors++; $display("FAIL reset_mid_scan: gate=%h trig=%h state=%0d busy=%b expected 0,0,IDLE,0", mon_gate, mon_trig, mon_state, mon_busy);
      end
      @(negedge clk);
      rst = 1'b0;
      model_reset();
   endtask

   task automatic test_random();
      int pick;
      byte unsigned unmapped[3] = '{8'h33, 8'h05, 8'h2C};
      sel = 0;
      for (int n = 0; n < 30; n++) begin
         for (int k = 0; k < 4; k++) begin
            pick = int'($urandom_range(0, 9));
            if (pick < 3) rep[k] = 0;
            else if (pick == 3) rep[k] = int'(unmapped[$urandom_range(0, 2)]);
            else if (pick < 6) rep[k] = rep[k];
            else rep[k] = int'(semi_codes[$urandom_range(0, 12)]);
         end
         run_scan($sformatf("random%0d", n), int'($urandom_range(0, 7)), 1'b0);
      end
   endtask

   initial begin
      for (int k = 0; k < 6; k++) rep[k] = 0;
      apply_reset();
      test_reset();
      test_single_press();
      test_release();
      test_replace();
      test_steal_six();
      test_dup_unmapped();
      test_overrun();
      test_reset_mid_scan();
      test_random();
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
